seven_seg_scan_n: RTL and testbench
===================================

Name: seven_seg_scan_n

Overview:
- Parametrised successor of the team's 4-digit hex display driver.
- Time-multiplexes NUM_DIGITS hex digits with decimal points onto one shared segment bus.
- Adds double-buffered, tear-free updates, anti-ghosting blanking, optional leading-zero suppression and a frame strobe.
- Sits between the datapath/top-level and the board's common-anode display pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (legal 1..8).
- REFRESH_DIV, 65536, clk cycles per digit slot (power of two, >= 32).
- BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off (< REFRESH_DIV/2).
- ACTIVE_LOW, 1, 1 = seg/dp/an are active-low; 0 = active-high.

Ports:
- clk  input  1  system clock; the block's only clock.
- rst  input  1  synchronous, active-high reset.
- number  input  4*NUM_DIGITS  hex value; nibble i drives digit i, where digit 0 is rightmost.
- dp_in  input  NUM_DIGITS  decimal-point request per digit.
- load  input  1  1-cycle strobe; captures number/dp_in into the pending buffer.
- lz_blank  input  1  1 = suppress leading zeros.
- bright  input  4  brightness level; used only with SEG7_DIMMING_EN.
- seg  output  7  segments {g,f,e,d,c,b,a}.
- dp  output  1  decimal-point segment.
- an  output  NUM_DIGITS  anode enables.
- frame_tick  output  1  1-cycle pulse at each frame start.

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high.
- Reset values:
  - seg, dp and an are all inactive (all 1 when ACTIVE_LOW).
  - frame_tick = 0.
  - div_cnt = 0, digit_idx = 0.
  - pending and active buffers cleared to 0.
  - rst asserted mid-frame aborts the scan; scanning restarts at digit 0 on the first cycle after rst deasserts.
- Scan counters:
  - div_cnt counts 0..REFRESH_DIV-1 and then wraps to 0.
  - On each wrap, digit_idx increments; after NUM_DIGITS-1 it wraps to 0.
  - The wrap of digit_idx to 0 is the frame boundary.
- Buffers:
  - load=1 captures number/dp_in into pending on that edge.
  - active is updated from pending only at a frame boundary, so a frame never mixes old and new digits.
  - load coinciding with a frame boundary: the incoming values go straight to active (bypass) and to pending.
  - Multiple loads within one frame: the last one wins.
- frame_tick is registered and high for exactly one cycle, the cycle after a frame boundary.
- Outputs are registered; latency is 1 cycle from the div_cnt/digit_idx state.
- During slot k:
  - When div_cnt < BLANK_CYCLES, all anodes are off.
  - Otherwise an[k] is on, all other anodes are off, seg = decode(active nibble k) and dp = active dp[k].
- Leading-zero suppression:
  - With lz_blank=1, digit k is suppressed when all active nibbles k..NUM_DIGITS-1 are zero and k != 0.
  - A suppressed digit has its anode held off for the whole slot; its dp is also off.
  - Digit 0 is always shown, so value 0 displays "0".
- Decode table (active-high a..g; inverted when ACTIVE_LOW):
  - 0-9 standard digits.
  - A, b, C, d, E, F.
- Only the one-hot an pattern is ever driven; two anodes are never on together.

Optional Feature:
- Macro: SEG7_DIMMING_EN.
- Defined:
  - The lit portion of each slot is additionally gated by PWM.
  - phase = div_cnt[top 4 bits]; the anode is on only when phase <= bright.
  - bright=15 gives full on; bright=0 gives 1/16 duty.
  - bright is sampled at each frame boundary.
- Undefined: bright is ignored and the lit portion runs at full duty.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry hex-to-segment constant table (active-high);
  - localparam SEG_OFF;
  - a function to compute the digit-index width, clog2(NUM_DIGITS) with a minimum of 1.
- Sub-module seg7_decoder: combinational nibble -> 7-bit segment pattern, with polarity applied by the parent.
- The top level holds the counters, buffers, blanking, PWM and output registers.

Test Plan:
- Common settings: NUM_DIGITS=4, REFRESH_DIV=32, BLANK_CYCLES=2, ACTIVE_LOW=1 unless stated otherwise.
- Reset and first frame:
  - Stimulus: rst for 3 cycles, then load number=16'h12AF.
  - Required response:
    - After reset: an=4'b1111, seg=7'h7F, frame_tick=0.
    - From the next frame: an=1110 with seg=7'b0001110 (F) for slot 0, then an=1101 with seg=7'b0001000 (A) for slot 1.
- Anti-ghosting blanking:
  - Stimulus: scan any displayed value.
  - Required response: an=1111 for exactly 2 cycles at the start of every slot; never more than one anode low.
- Tear-free update:
  - Stimulus: with 16'h1111 displayed, load 16'h2222 mid-frame.
  - Required response: the remaining slots of that frame still show 1; every slot of the next frame shows 2.
- Load on frame boundary:
  - Stimulus: load 16'h0042 in the same cycle as the boundary.
  - Required response: the frame starting at that boundary shows 0042.
- Leading-zero suppression:
  - Stimulus: lz_blank=1 with 16'h0042, then with 16'h0000.
  - Required response:
    - For 0042, slots 2 and 3 keep an=1111 for the whole slot.
    - For 0000, only digit 0 lights, showing "0".
- Dimming (SEG7_DIMMING_EN defined):
  - Stimulus: bright=3, REFRESH_DIV=64.
  - Required response: an[k] is low only for div_cnt 2..15; frame_tick pulses every 256 cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment driver: the hex-to-segment
// table (active-high, bit order {g,f,e,d,c,b,a}), the all-off pattern and the
// digit-index width helper.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

    // Width of the digit index; a single-digit display still needs one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational nibble to seven-segment pattern (active-high); the parent
// applies the board polarity.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seven_seg_scan_n.sv
// Time-multiplexed NUM_DIGITS hex display driver with double-buffered updates,
// anti-ghosting blanking, optional leading-zero suppression and a frame strobe.
// Optional PWM dimming is compiled in with the SEG7_DIMMING_EN macro.
module seven_seg_scan_n
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 65536,
    parameter int BLANK_CYCLES = 16,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] number,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lz_blank,
    input  logic [3:0]              bright,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int NUM_W = 4 * NUM_DIGITS;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic             POL       = (ACTIVE_LOW != 0);

    localparam logic [6:0]            SEG_IDLE = SEG_OFF ^ {7{POL}};
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = {NUM_DIGITS{POL}};

    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
    logic [NUM_W-1:0]      pend_num_q, pend_num_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic [NUM_W-1:0]      act_num_q, act_num_d;
    logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_tick_q, frame_tick_d;

    logic                  div_wrap;
    logic                  frame_end;
    logic                  zero_run;
    logic [NUM_DIGITS-1:0] supp;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_supp;
    logic                  pwm_on;
    logic                  lit;
    logic [NUM_DIGITS-1:0] an_hot;
    logic [6:0]            dec_seg;

`ifdef SEG7_DIMMING_EN
    logic [3:0]            bright_q, bright_d;
`else
    logic                  unused_bright;
    assign unused_bright = ^bright;
`endif

    seg7_decoder u_dec (
        .nib (cur_nib),
        .seg (dec_seg)
    );

    // Scan counters and the pending/active buffers; active only changes at a frame boundary.
    always_comb begin
        div_wrap     = (div_cnt_q == DIV_LAST);
        frame_end    = div_wrap && (digit_idx_q == IDX_LAST);
        div_cnt_d    = div_cnt_q + 1'b1;
        digit_idx_d  = digit_idx_q;
        if (div_wrap) begin
            digit_idx_d = frame_end ? '0 : digit_idx_q + 1'b1;
        end
        // A load on the boundary edge reaches active directly through pend_*_d.
        pend_num_d   = load ? number : pend_num_q;
        pend_dp_d    = load ? dp_in  : pend_dp_q;
        act_num_d    = frame_end ? pend_num_d : act_num_q;
        act_dp_d     = frame_end ? pend_dp_d  : act_dp_q;
        frame_tick_d = frame_end;
`ifdef SEG7_DIMMING_EN
        bright_d     = frame_end ? bright : bright_q;
`endif
    end

    // Per-digit leading-zero flags and selection of the digit in the current slot.
    always_comb begin
        zero_run = 1'b1;
        supp     = '0;
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        cur_supp = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (act_num_q[k*4 +: 4] == 4'h0);
            supp[k]  = lz_blank && zero_run && (k != 0);
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_idx_q == IDX_W'(k)) begin
                cur_nib  = act_num_q[k*4 +: 4];
                cur_dp   = act_dp_q[k];
                cur_supp = supp[k];
            end
        end
    end

    // Blanking, suppression and PWM gating, then polarity; only one anode can be lit.
    always_comb begin
        pwm_on = 1'b1;
`ifdef SEG7_DIMMING_EN
        pwm_on = (div_cnt_q[DIV_W-1 -: 4] <= bright_q);
`endif
        lit    = (div_cnt_q >= BLANK_END) && !cur_supp && pwm_on;
        an_hot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            an_hot[k] = lit && (digit_idx_q == IDX_W'(k));
        end
        an_d  = an_hot ^ AN_IDLE;
        seg_d = lit ? (dec_seg ^ {7{POL}}) : SEG_IDLE;
        dp_d  = (lit && cur_dp) ^ POL;
    end

    // State and output registers; reset aborts the scan and restarts at digit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q    <= '0;
            digit_idx_q  <= '0;
            pend_num_q   <= '0;
            pend_dp_q    <= '0;
            act_num_q    <= '0;
            act_dp_q     <= '0;
            seg_q        <= SEG_IDLE;
            dp_q         <= POL;
            an_q         <= AN_IDLE;
            frame_tick_q <= 1'b0;
`ifdef SEG7_DIMMING_EN
            bright_q     <= 4'hF;
`endif
        end else begin
            div_cnt_q    <= div_cnt_d;
            digit_idx_q  <= digit_idx_d;
            pend_num_q   <= pend_num_d;
            pend_dp_q    <= pend_dp_d;
            act_num_q    <= act_num_d;
            act_dp_q     <= act_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
`ifdef SEG7_DIMMING_EN
            bright_q     <= bright_d;
`endif
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan_n.sv
// Directed testbench for seven_seg_scan_n (4 digits, active-low, 2 blank cycles).
module tb_seven_seg_scan_n;

`ifdef SEG7_DIMMING_EN
    localparam int R = 64;
`else
    localparam int R = 32;
`endif
    localparam int ND  = 4;
    localparam int BLK = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] number;
    logic [3:0]  dp_in;
    logic        load;
    logic        lz_blank;
    logic [3:0]  bright;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;

    seven_seg_scan_n #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (R),
        .BLANK_CYCLES (BLK),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .number     (number),
        .dp_in      (dp_in),
        .load       (load),
        .lz_blank   (lz_blank),
        .bright     (bright),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Active-high {g..a} reference patterns.
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;  default: return 7'b1110001;
        endcase
    endfunction

    // Runs one full frame starting from the cycle where the scan sits at digit 0,
    // div_cnt 0; optionally pulses load at two positions (position = edge index).
    task automatic run_frame(input string name, input logic [15:0] val,
                             input logic [3:0] dpv, input logic lz, input int brt,
                             input int l1_at, input logic [15:0] l1_val,
                             input int l2_at, input logic [15:0] l2_val);
        int slot_bad [4];
        int bad_pos [4];
        logic [3:0] g_an [4];
        logic [6:0] g_seg [4];
        logic g_dp [4];
        logic [3:0] x_an [4];
        logic [6:0] x_seg [4];
        logic x_dp [4];
        int tick_bad, tick_pos;
        logic tick_got;
        int pos, k, d;
        logic [3:0] nib;
        logic supp_k, lit;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic e_dp;
        tick_bad = 0; tick_pos = 0; tick_got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            slot_bad[i] = 0; bad_pos[i] = 0;
            g_an[i] = '0; g_seg[i] = '0; g_dp[i] = 1'b0;
            x_an[i] = '0; x_seg[i] = '0; x_dp[i] = 1'b0;
        end
        for (int c = 1; c <= 4 * R; c++) begin
            if (c - 1 == l1_at) begin number = l1_val; load = 1'b1; end
            else if (c - 1 == l2_at) begin number = l2_val; load = 1'b1; end
            @(posedge clk);
            #1 load = 1'b0;
            @(negedge clk);
            pos = c - 1;
            k = pos / R;
            d = pos % R;
            nib = val[k*4 +: 4];
            supp_k = lz && (k != 0) && ((val >> (4 * k)) == 16'h0);
            lit = (d >= BLK) && !supp_k;
`ifdef SEG7_DIMMING_EN
            lit = lit && ((d / (R / 16)) <= brt);
`endif
            e_an  = lit ? ~(4'b0001 << k) : 4'b1111;
            e_seg = lit ? ~seg_of(nib) : 7'h7F;
            e_dp  = lit ? ~dpv[k] : 1'b1;
            if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
                if (slot_bad[k] == 0) begin
                    bad_pos[k] = d; g_an[k] = an; g_seg[k] = seg; g_dp[k] = dp;
                    x_an[k] = e_an; x_seg[k] = e_seg; x_dp[k] = e_dp;
                end
                slot_bad[k]++;
            end
            if (frame_tick !== (c == 4 * R)) begin
                if (tick_bad == 0) begin tick_pos = pos; tick_got = frame_tick; end
                tick_bad++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (slot_bad[i] != 0) begin
                errors++;
                $display("FAIL %s slot%0d div%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b (%0d bad cycles)",
                         name, i, bad_pos[i], g_an[i], g_seg[i], g_dp[i], x_an[i], x_seg[i], x_dp[i], slot_bad[i]);
            end
        end
        checks++;
        if (tick_bad != 0) begin
            errors++;
            $display("FAIL %s frame_tick: got %b at pos %0d, expected a single pulse at end of frame (%0d bad cycles)",
                     name, tick_got, tick_pos, tick_bad);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an: got %b expected 1111", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h expected 7f", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b expected 1", dp); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", frame_tick); end
        rst = 1'b0;
        // Cleared buffers show 0000 with no points while 12AF waits in pending.
        run_frame("post_reset", 16'h0000, 4'b0000, 1'b0, 15, 0, 16'h12AF, -1, 16'h0);
    endtask

    task automatic test_first_frame();
        run_frame("first_frame", 16'h12AF, 4'b0101, 1'b0, 15, 10, 16'h1111, -1, 16'h0);
    endtask

    task automatic test_tear_free();
        run_frame("tear_old", 16'h1111, 4'b0101, 1'b0, 15, R + 5, 16'h2222, -1, 16'h0);
    endtask

    task automatic test_load_boundary();
        run_frame("tear_new", 16'h2222, 4'b0101, 1'b0, 15, 4 * R - 1, 16'h0042, -1, 16'h0);
        run_frame("boundary_load", 16'h0042, 4'b0101, 1'b0, 15, -1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_lz_blank();
        lz_blank = 1'b1;
        run_frame("lz_0042", 16'h0042, 4'b0101, 1'b1, 15, 3, 16'h0000, -1, 16'h0);
        run_frame("lz_0000", 16'h0000, 4'b0101, 1'b1, 15, 5, 16'h5678, 40, 16'h9ABC);
        lz_blank = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_frame("last_load_wins", 16'h9ABC, 4'b0101, 1'b0, 15, -1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_midframe_reset();
        repeat (50) @(posedge clk);
        @(negedge clk);
        number = 16'h7777; load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL midrst_an: got %b expected 1111", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL midrst_seg: got %h expected 7f", seg); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_frame("midrst_f1", 16'h0000, 4'b0000, 1'b0, 15, -1, 16'h0, -1, 16'h0);
        run_frame("midrst_f2", 16'h0000, 4'b0000, 1'b0, 15, 20, 16'h3C5E, -1, 16'h0);
        run_frame("midrst_f3", 16'h3C5E, 4'b0101, 1'b0, 15, -1, 16'h0, -1, 16'h0);
    endtask

`ifdef SEG7_DIMMING_EN
    task automatic test_dimming();
        bright = 4'd3;
        run_frame("dim_pre", 16'h3C5E, 4'b0101, 1'b0, 15, -1, 16'h0, -1, 16'h0);
        run_frame("dim_b3", 16'h3C5E, 4'b0101, 1'b0, 3, -1, 16'h0, -1, 16'h0);
        bright = 4'd15;
    endtask
`endif

    initial begin
        rst = 1'b1; load = 1'b0; number = 16'h0; dp_in = 4'b0101;
        lz_blank = 1'b0; bright = 4'd15;
        test_reset();
        test_first_frame();
        test_tear_free();
        test_load_boundary();
        test_lz_blank();
        test_back_to_back();
        test_midframe_reset();
`ifdef SEG7_DIMMING_EN
        test_dimming();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
